// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder.
package sa_pkg;

  // Default element width and lane count.
  localparam int SA_DATA_SIZE  = 8;
  localparam int SA_ARRAY_SIZE = 2;

  // Width of one lane slice inside a packed row.
  localparam int SA_LANE_W = SA_DATA_SIZE;

  // Feeder controller states; the encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } sa_state_e;

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Upstream weight/activation handshake bundle of the skew feeder.
// Handshake: a row transfers on a rising clk edge where valid && ready are
// both high; the master holds the row stable while valid is high, and
// ready never depends combinationally on valid.
interface sa_skew_feeder_if
  import sa_pkg::*;
#(
  parameter int DATA_SIZE  = SA_DATA_SIZE,
  parameter int ARRAY_SIZE = SA_ARRAY_SIZE
) ();

  logic                             w_valid;
  logic                             w_ready;
  logic [ARRAY_SIZE*DATA_SIZE-1:0]  w_row;
  logic                             in_valid;
  logic                             in_ready;
  logic [ARRAY_SIZE*DATA_SIZE-1:0]  in_row;
  logic                             in_last;

  modport master (
    output w_valid, w_row, in_valid, in_row, in_last,
    input  w_ready, in_ready
  );

  modport slave (
    input  w_valid, w_row, in_valid, in_row, in_last,
    output w_ready, in_ready
  );

endinterface

// File: rtl/sa_delay_line.sv
// Fixed-depth data+valid shift register; one instance per array lane.
module sa_delay_line #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] d_in,
  input  logic                 v_in,
  output logic [DATA_SIZE-1:0] d_out,
  output logic                 v_out
);

  logic [DATA_SIZE-1:0] data_q [DEPTH];
  logic [DATA_SIZE-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_d;

  // Next stage contents: new element at stage 0, everything else moves up one.
  always_comb begin
    data_d[0]  = d_in;
    valid_d    = '0;
    valid_d[0] = v_in;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i]  = data_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign d_out = data_q[DEPTH-1];
  assign v_out = valid_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Systolic-array feeder: loads weight rows, then streams activation rows with
// a per-lane diagonal skew (lane k lags lane 0 by k cycles), drains the skew
// and pulses done. Optional macro SA_FEEDER_ROWCNT_EN adds a saturating
// rows_streamed counter output.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int DATA_SIZE  = SA_DATA_SIZE,
  parameter int ARRAY_SIZE = SA_ARRAY_SIZE,
  parameter int CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  sa_skew_feeder_if.slave                 up,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] w_out,
  output logic [CNT_W-1:0]                w_sel,
  output logic                            w_load,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] a_out,
  output logic [ARRAY_SIZE-1:0]           a_valid,
  output logic                            busy,
  output logic                            done,
  output sa_state_e                       state_dbg
`ifdef SA_FEEDER_ROWCNT_EN
  ,
  output logic [CNT_W-1:0]                rows_streamed
`endif
);

  localparam int ROW_W = ARRAY_SIZE * DATA_SIZE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ARRAY_SIZE - 1);

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] w_sel_q, w_sel_d;
  logic [ROW_W-1:0] w_out_q, w_out_d;
  logic             w_load_q, w_load_d;
  logic             done_q, done_d;
  logic             w_ready_c, in_ready_c, w_acc, in_acc;

  // Ready depends on state only; the array never back-pressures the stream.
  always_comb begin
    w_ready_c  = (state_q == ST_IDLE) || (state_q == ST_LOAD_W);
    in_ready_c = (state_q == ST_STREAM);
    w_acc      = up.w_valid && w_ready_c;
    in_acc     = up.in_valid && in_ready_c;
  end

  assign up.w_ready  = w_ready_c;
  assign up.in_ready = in_ready_c;

  // Next state, weight write strobe and drain countdown.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    w_out_d     = w_out_q;
    w_sel_d     = w_sel_q;
    w_load_d    = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_acc) begin
          w_out_d   = up.w_row;
          w_sel_d   = '0;
          w_load_d  = 1'b1;
          row_cnt_d = CNT_W'(1);
          state_d   = (ARRAY_SIZE == 1) ? ST_STREAM : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (w_acc) begin
          w_out_d   = up.w_row;
          w_sel_d   = row_cnt_q;
          w_load_d  = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == LAST_IDX) state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (in_acc && up.in_last) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Last lane's final element leaves during the last drain cycle.
        if (drain_cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      w_out_q     <= '0;
      w_sel_q     <= '0;
      w_load_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      w_out_q     <= w_out_d;
      w_sel_q     <= w_sel_d;
      w_load_q    <= w_load_d;
      done_q      <= done_d;
    end
  end

  assign w_out     = w_out_q;
  assign w_sel     = w_sel_q;
  assign w_load    = w_load_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  // Lane inputs: accepted elements, or zero bubbles when nothing is accepted.
  logic [DATA_SIZE-1:0] lane_in  [ARRAY_SIZE];
  logic [DATA_SIZE-1:0] lane_out [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] lane_v;

  always_comb begin
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      lane_in[k] = in_acc ? up.in_row[k*DATA_SIZE +: DATA_SIZE] : '0;
    end
  end

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    sa_delay_line #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (k + 1)
    ) u_delay (
      .clk   (clk),
      .reset (reset),
      .d_in  (lane_in[k]),
      .v_in  (in_acc),
      .d_out (lane_out[k]),
      .v_out (lane_v[k])
    );
    // Invalid lanes present zero so cells accumulate nothing.
    assign a_out[k*DATA_SIZE +: DATA_SIZE] = lane_v[k] ? lane_out[k] : '0;
  end

  assign a_valid = lane_v;

`ifdef SA_FEEDER_ROWCNT_EN
  logic [CNT_W-1:0] rows_q, rows_d;

  // Count accepted activation rows per job, saturating at all-ones.
  always_comb begin
    rows_d = rows_q;
    if ((state_q == ST_IDLE) && w_acc) rows_d = '0;
    else if (in_acc && (rows_q != '1)) rows_d = rows_q + 1'b1;
  end

  // Row counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rows_q <= '0;
    else        rows_q <= rows_d;
  end

  assign rows_streamed = rows_q;
`endif

endmodule
